// File: rtl/gelato_decode_pipe_pkg.sv
// Shared types for the gelato decode stage: decoded instruction bundle,
// RV32 opcode / funct3 constants and the decode FSM state.
package gelato_types;

    localparam int MASK_W = 32;

    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] OPCODE_NOOP   = 7'b0001111;

    localparam logic [2:0] FUNCT3_SEQ = 3'b000;
    localparam logic [2:0] FUNCT3_SNE = 3'b001;

    typedef struct packed {
        logic [6:0]        opcode;
        logic [4:0]        rd;
        logic [2:0]        funct3;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [6:0]        funct7;
        logic [31:0]       imm;
        logic [MASK_W-1:0] mask;
        logic              illegal;
    } inst_t;

    typedef enum logic {
        S_IDLE,
        S_LOOKUP
    } decode_state_t;

endpackage

// File: rtl/gelato_decode_pipe_fifo.sv
// Circular-buffer FIFO queueing decoded instructions towards the I-Buffer.
// Head word is presented combinationally and stays stable until popped.
module gelato_decode_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= inc(wr_ptr);
            end
            if (do_pop) rd_ptr <= inc(rd_ptr);
            if (do_push && !do_pop) count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/gelato_decode_pipe.sv
// Decode stage between I-Fetch and I-Buffer with split-table lookup/update.
// Optional perf counters when GELATO_DECODE_PERF_EN is defined.
module gelato_decode_pipe
    import gelato_types::*;
#(
    parameter int PC_WIDTH    = 32,
    parameter int NUM_WARPS   = 16,
    parameter int NUM_THREADS = 32,
    parameter int SPLIT_W     = 4,
    parameter int OUT_DEPTH   = 2,
    localparam int WARP_W     = $clog2(NUM_WARPS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     rdy,
    input  logic                     if_valid,
    output logic                     if_ready,
    input  logic [PC_WIDTH-1:0]      if_pc,
    input  logic [31:0]              if_inst,
    input  logic [WARP_W-1:0]        if_warp_num,
    input  logic [SPLIT_W-1:0]       if_split_table_num,
    output logic                     sp_lookup_valid,
    output logic [WARP_W-1:0]        sp_warp_num,
    output logic [SPLIT_W-1:0]       sp_split_table_num,
    input  logic                     sp_mask_valid,
    input  logic [NUM_THREADS-1:0]   sp_thread_mask,
    output logic                     sp_update_valid,
    output logic                     sp_activate,
    output logic                     sp_stall,
    output logic [PC_WIDTH-1:0]      sp_updated_pc,
    output logic                     ib_valid,
    input  logic                     ib_ready,
    output logic [$bits(inst_t)-1:0] ib_inst
`ifdef GELATO_DECODE_PERF_EN
    ,
    output logic [31:0]              perf_decoded,
    output logic [31:0]              perf_stalled,
    output logic [31:0]              perf_illegal
`endif
);

    localparam int CNT_W = $clog2(OUT_DEPTH + 1);

    decode_state_t       state, state_nxt;
    logic [PC_WIDTH-1:0] pc_q;
    logic [31:0]         inst_q;
    logic [6:0]          op;
    inst_t               dec;
    logic                accept, push, pop, full, empty;
    logic [CNT_W-1:0]    count;
    logic                upd_q, act_q, stall_q;
    logic [PC_WIDTH-1:0] upd_pc_q;
    logic                act_d, stall_d;
    logic [PC_WIDTH-1:0] upd_pc_d;

    assign if_ready = rst_n && rdy && (state == S_IDLE)
                      && (count < CNT_W'(OUT_DEPTH));
    assign accept   = if_valid && if_ready;
    assign push     = rdy && (state == S_LOOKUP) && sp_mask_valid;
    assign pop      = rdy && ib_valid && ib_ready;
    assign ib_valid = !empty;
    assign op       = inst_q[6:0];

    assign sp_lookup_valid = (state == S_LOOKUP);
    assign sp_update_valid = upd_q && rdy;
    assign sp_activate     = act_q;
    assign sp_stall        = stall_q;
    assign sp_updated_pc   = upd_pc_q;

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:   if (accept) state_nxt = S_LOOKUP;
            S_LOOKUP: if (push) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        dec        = '0;
        dec.opcode = op;
        dec.mask   = MASK_W'(sp_thread_mask);
        unique case (op)
            OPCODE_LUI, OPCODE_AUIPC: begin
                dec.rd  = inst_q[11:7];
                dec.imm = {inst_q[31:12], 12'b0};
            end
            OPCODE_JAL: begin
                dec.rd  = inst_q[11:7];
                dec.imm = {{11{inst_q[31]}}, inst_q[31], inst_q[19:12],
                           inst_q[20], inst_q[30:21], 1'b0};
            end
            OPCODE_JALR, OPCODE_LOAD, OPCODE_OP_IMM: begin
                dec.rd     = inst_q[11:7];
                dec.funct3 = inst_q[14:12];
                dec.rs1    = inst_q[19:15];
                dec.imm    = {{20{inst_q[31]}}, inst_q[31:20]};
            end
            OPCODE_STORE: begin
                dec.funct3 = inst_q[14:12];
                dec.rs1    = inst_q[19:15];
                dec.rs2    = inst_q[24:20];
                dec.imm    = {{20{inst_q[31]}}, inst_q[31:25], inst_q[11:7]};
            end
            OPCODE_BRANCH: begin
                dec.funct3 = inst_q[14:12];
                dec.rs1    = inst_q[19:15];
                dec.rs2    = inst_q[24:20];
                dec.imm    = {{19{inst_q[31]}}, inst_q[31], inst_q[7],
                              inst_q[30:25], inst_q[11:8], 1'b0};
            end
            OPCODE_OP: begin
                dec.rd     = inst_q[11:7];
                dec.funct3 = inst_q[14:12];
                dec.rs1    = inst_q[19:15];
                dec.rs2    = inst_q[24:20];
                dec.funct7 = inst_q[31:25];
            end
            OPCODE_NOOP: ;
            default: dec.illegal = 1'b1;
        endcase
    end

    // Control transfers whose target needs register state are resolved later.
    always_comb begin
        act_d    = !((op == OPCODE_BRANCH) &&
                     (dec.funct3 == FUNCT3_SEQ || dec.funct3 == FUNCT3_SNE));
        stall_d  = 1'b0;
        upd_pc_d = pc_q + PC_WIDTH'(4);
        if (dec.illegal) begin
            act_d    = 1'b1;
            stall_d  = 1'b1;
            upd_pc_d = '0;
        end else if (op == OPCODE_AUIPC || op == OPCODE_BRANCH
                     || op == OPCODE_JALR) begin
            stall_d  = 1'b1;
            upd_pc_d = '0;
        end else if (op == OPCODE_JAL) begin
            upd_pc_d = pc_q + PC_WIDTH'(dec.imm);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= S_IDLE;
            pc_q               <= '0;
            inst_q             <= '0;
            sp_warp_num        <= '0;
            sp_split_table_num <= '0;
            upd_q              <= 1'b0;
            act_q              <= 1'b0;
            stall_q            <= 1'b0;
            upd_pc_q           <= '0;
        end else if (rdy) begin
            state <= state_nxt;
            upd_q <= push;
            if (accept) begin
                pc_q               <= if_pc;
                inst_q             <= if_inst;
                sp_warp_num        <= if_warp_num;
                sp_split_table_num <= if_split_table_num;
            end
            if (push) begin
                act_q    <= act_d;
                stall_q  <= stall_d;
                upd_pc_q <= upd_pc_d;
            end
        end
    end

    gelato_decode_fifo #(
        .WIDTH ($bits(inst_t)),
        .DEPTH (OUT_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push && !full),
        .pop   (pop),
        .din   (dec),
        .dout  (ib_inst),
        .full  (full),
        .empty (empty),
        .count (count)
    );

`ifdef GELATO_DECODE_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_decoded <= '0;
            perf_stalled <= '0;
            perf_illegal <= '0;
        end else if (push) begin
            if (perf_decoded != '1) perf_decoded <= perf_decoded + 1'b1;
            if (stall_d && perf_stalled != '1)
                perf_stalled <= perf_stalled + 1'b1;
            if (dec.illegal && perf_illegal != '1)
                perf_illegal <= perf_illegal + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_gelato_decode_pipe.sv
// Bench for gelato_decode_pipe: directed corner cases plus random words
// encoded from (kind, fields, immediate) and checked against that intent.
module tb_gelato_decode_pipe;
    import gelato_types::*;

    typedef enum int {
        K_LUI, K_AUIPC, K_JAL, K_JALR, K_BR, K_LOAD,
        K_STORE, K_OPIMM, K_OP, K_NOOP, K_ILL
    } kind_e;

    typedef struct {
        logic [31:0] word;
        logic [31:0] pc;
        logic [31:0] upd;
        logic        stall;
        logic        act;
        inst_t       exp;
    } item_t;

    logic        clk = 0;
    logic        rst_n, rdy, if_valid, if_ready;
    logic [31:0] if_pc, if_inst;
    logic [3:0]  if_warp_num, if_split_table_num;
    logic        sp_lookup_valid;
    logic [3:0]  sp_warp_num, sp_split_table_num;
    logic        sp_mask_valid;
    logic [31:0] sp_thread_mask;
    logic        sp_update_valid, sp_activate, sp_stall;
    logic [31:0] sp_updated_pc;
    logic        ib_valid, ib_ready;
    logic [$bits(inst_t)-1:0] ib_inst;
`ifdef GELATO_DECODE_PERF_EN
    logic [31:0] perf_decoded, perf_stalled, perf_illegal;
`endif

    int    checks = 0;
    int    errors = 0;
    bit    rand_ib = 0;
    inst_t exp_q[$];

    gelato_decode_pipe dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .rdy                (rdy),
        .if_valid           (if_valid),
        .if_ready           (if_ready),
        .if_pc              (if_pc),
        .if_inst            (if_inst),
        .if_warp_num        (if_warp_num),
        .if_split_table_num (if_split_table_num),
        .sp_lookup_valid    (sp_lookup_valid),
        .sp_warp_num        (sp_warp_num),
        .sp_split_table_num (sp_split_table_num),
        .sp_mask_valid      (sp_mask_valid),
        .sp_thread_mask     (sp_thread_mask),
        .sp_update_valid    (sp_update_valid),
        .sp_activate        (sp_activate),
        .sp_stall           (sp_stall),
        .sp_updated_pc      (sp_updated_pc),
        .ib_valid           (ib_valid),
        .ib_ready           (ib_ready),
        .ib_inst            (ib_inst)
`ifdef GELATO_DECODE_PERF_EN
        ,
        .perf_decoded       (perf_decoded),
        .perf_stalled       (perf_stalled),
        .perf_illegal       (perf_illegal)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ib) ib_ready = ($urandom_range(0, 3) != 0);
    endtask

    // Every accepted head must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && rdy && ib_valid && ib_ready) begin
            if (exp_q.size() == 0) chk("ib_unexpected", ib_valid, 1'b0);
            else begin
                chk("ib_inst", ib_inst, exp_q[0]);
                void'(exp_q.pop_front());
            end
        end
    end

    function automatic item_t mk(input kind_e k, input logic [31:0] pc,
                                 input logic [4:0] rd, input logic [4:0] rs1,
                                 input logic [4:0] rs2, input logic [2:0] f3,
                                 input logic [6:0] f7, input logic [31:0] v,
                                 input logic [31:0] mask,
                                 input logic [6:0] illop);
        item_t      it;
        logic [6:0] op;
        it.exp = '0;
        case (k)
            K_LUI:   op = 7'h37;
            K_AUIPC: op = 7'h17;
            K_JAL:   op = 7'h6F;
            K_JALR:  op = 7'h67;
            K_BR:    op = 7'h63;
            K_LOAD:  op = 7'h03;
            K_STORE: op = 7'h23;
            K_OPIMM: op = 7'h13;
            K_OP:    op = 7'h33;
            K_NOOP:  op = 7'h0F;
            default: op = illop;
        endcase
        case (k)
            K_LUI, K_AUIPC: begin
                it.word = {v[31:12], rd, op};
                it.exp.rd = rd; it.exp.imm = v;
            end
            K_JAL: begin
                it.word = {v[20], v[10:1], v[11], v[19:12], rd, op};
                it.exp.rd = rd; it.exp.imm = v;
            end
            K_JALR, K_LOAD, K_OPIMM: begin
                it.word = {v[11:0], rs1, f3, rd, op};
                it.exp.rd = rd; it.exp.funct3 = f3;
                it.exp.rs1 = rs1; it.exp.imm = v;
            end
            K_STORE: begin
                it.word = {v[11:5], rs2, rs1, f3, v[4:0], op};
                it.exp.funct3 = f3; it.exp.rs1 = rs1;
                it.exp.rs2 = rs2; it.exp.imm = v;
            end
            K_BR: begin
                it.word = {v[12], v[10:5], rs2, rs1, f3, v[4:1], v[11], op};
                it.exp.funct3 = f3; it.exp.rs1 = rs1;
                it.exp.rs2 = rs2; it.exp.imm = v;
            end
            K_OP: begin
                it.word = {f7, rs2, rs1, f3, rd, op};
                it.exp.rd = rd; it.exp.funct3 = f3; it.exp.rs1 = rs1;
                it.exp.rs2 = rs2; it.exp.funct7 = f7;
            end
            default: it.word = {v[31:7], op};
        endcase
        it.exp.opcode  = op;
        it.exp.mask    = mask;
        it.exp.illegal = (k == K_ILL);
        it.pc    = pc;
        it.stall = (k == K_AUIPC || k == K_BR || k == K_JALR || k == K_ILL);
        it.act   = !(k == K_BR && f3 < 3'd2);
        it.upd   = it.stall ? 32'h0 : (k == K_JAL ? pc + v : pc + 32'd4);
        return it;
    endfunction

    function automatic item_t rnd_item();
        kind_e      k;
        int         t;
        logic [31:0] v;
        logic [6:0] ills [8] = '{7'h7F, 7'h0B, 7'h2B, 7'h5B,
                                 7'h7B, 7'h73, 7'h00, 7'h57};
        k = kind_e'($urandom_range(0, 10));
        case (k)
            K_LUI, K_AUIPC: v = $urandom & 32'hFFFF_F000;
            K_JAL: begin
                t = (int'($urandom_range(0, 1048575)) - 524288) * 2;
                v = t;
            end
            K_BR: begin
                t = (int'($urandom_range(0, 4095)) - 2048) * 2;
                v = t;
            end
            K_JALR, K_LOAD, K_OPIMM, K_STORE: begin
                t = int'($urandom_range(0, 4095)) - 2048;
                v = t;
            end
            default: v = $urandom;
        endcase
        return mk(k, $urandom & 32'hFFFF_FFFC, 5'($urandom), 5'($urandom),
                  5'($urandom), 3'($urandom), 7'($urandom), v, $urandom,
                  ills[$urandom_range(0, 7)]);
    endfunction

    task automatic run(input item_t it, input logic [3:0] warp,
                       input logic [3:0] entry, input int delay);
        int n = 0;
        if_pc = it.pc;
        if_inst = it.word;
        if_warp_num = warp;
        if_split_table_num = entry;
        if_valid = 1;
        while (!if_ready && n < 200) begin
            tick();
            n++;
        end
        chk("accept_wait", if_ready, 1'b1);
        tick();
        if_valid = 0;
        chk("lookup_valid", sp_lookup_valid, 1'b1);
        chk("lookup_warp", sp_warp_num, warp);
        chk("lookup_entry", sp_split_table_num, entry);
        chk("upd_pulse_end", sp_update_valid, 1'b0);
        repeat (delay) begin
            tick();
            chk("lookup_hold", sp_lookup_valid, 1'b1);
        end
        sp_mask_valid = 1;
        sp_thread_mask = it.exp.mask;
        exp_q.push_back(it.exp);
        tick();
        sp_mask_valid = 0;
        chk("upd_valid", sp_update_valid, 1'b1);
        chk("upd_stall", sp_stall, it.stall);
        chk("upd_act", sp_activate, it.act);
        chk("upd_pc", sp_updated_pc, it.upd);
        chk("lookup_drop", sp_lookup_valid, 1'b0);
        chk("ib_valid_lat", ib_valid, 1'b1);
    endtask

    initial begin
        item_t a, b, c;
        inst_t h;
        int n;
        rst_n = 0; rdy = 1; if_valid = 0; if_pc = 0; if_inst = 0;
        if_warp_num = 0; if_split_table_num = 0; sp_mask_valid = 0;
        sp_thread_mask = 0; ib_ready = 1;
        #2;
        chk("rst_if_ready", if_ready, 1'b0);
        chk("rst_ib_valid", ib_valid, 1'b0);
        chk("rst_ib_inst", ib_inst, '0);
        chk("rst_lookup", sp_lookup_valid, 1'b0);
        chk("rst_upd", sp_update_valid, 1'b0);
        chk("rst_upd_pc", sp_updated_pc, 32'h0);
        tick(); tick();
        rst_n = 1;
        tick();
        chk("idle_ready", if_ready, 1'b1);

        // ADDI x1,x2,-1
        a = mk(K_OPIMM, 32'h100, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0,
               32'hFFFF_FFFF, 32'hFFFF_FFFF, 7'h0);
        run(a, 4'd3, 4'd5, 1);
        h = inst_t'(ib_inst);
        chk("addi_imm", h.imm, 32'hFFFF_FFFF);
        chk("addi_pc", sp_updated_pc, 32'h104);
        chk("addi_stall", sp_stall, 1'b0);

        a = mk(K_JAL, 32'h1000, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0,
               32'h800, 32'h1234, 7'h0);
        run(a, 4'd1, 4'd2, 0);
        chk("jal_pc", sp_updated_pc, 32'h1800);
        chk("jal_stall", sp_stall, 1'b0);

        a = mk(K_JALR, 32'h2000, 5'd1, 5'd7, 5'd0, 3'd0, 7'd0,
               32'h10, 32'h1, 7'h0);
        run(a, 4'd2, 4'd0, 0);
        chk("jalr_stall", sp_stall, 1'b1);
        chk("jalr_pc", sp_updated_pc, 32'h0);

        a = mk(K_BR, 32'h300, 5'd0, 5'd4, 5'd5, 3'd0, 7'd0,
               32'hFFFF_FFF8, 32'hF0F0, 7'h0);
        run(a, 4'd9, 4'd1, 5);
        chk("br_act", sp_activate, 1'b0);
        chk("br_stall", sp_stall, 1'b1);

        a = mk(K_ILL, 32'h400, 0, 0, 0, 0, 0, 32'h0, 32'h5, 7'h7F);
        run(a, 4'd4, 4'd4, 0);
        chk("ill_stall", sp_stall, 1'b1);
        chk("ill_act", sp_activate, 1'b1);
        h = inst_t'(ib_inst);
        chk("ill_flag", h.illegal, 1'b1);
`ifdef GELATO_DECODE_PERF_EN
        tick();
        chk("perf_illegal", perf_illegal, 32'd1);
`endif
        tick(); tick();

        // Backpressure: two words fill the FIFO, third waits for a pop.
        ib_ready = 0;
        run(rnd_item(), 4'd1, 4'd1, 0);
        run(rnd_item(), 4'd2, 4'd2, 0);
        tick();
        chk("bp_full_ready", if_ready, 1'b0);
        c = rnd_item();
        if_inst = c.word; if_pc = c.pc; if_valid = 1;
        repeat (3) begin
            tick();
            chk("bp_hold_ready", if_ready, 1'b0);
        end
        ib_ready = 1;
        tick();
        ib_ready = 0;
        chk("bp_after_pop", if_ready, 1'b1);
        run(c, 4'd3, 4'd3, 0);
        ib_ready = 1;
        tick(); tick(); tick();
        chk("bp_drained", ib_valid, 1'b0);

        // rdy=0 for 4 cycles mid-transfer with a queued head.
        ib_ready = 0;
        a = rnd_item();
        run(a, 4'd6, 4'd6, 0);
        b = rnd_item();
        if_inst = b.word; if_pc = b.pc; if_valid = 1;
        tick();
        chk("frz_lookup0", sp_lookup_valid, 1'b1);
        rdy = 0; ib_ready = 1; sp_mask_valid = 1;
        sp_thread_mask = b.exp.mask;
        repeat (4) begin
            tick();
            chk("frz_lookup", sp_lookup_valid, 1'b1);
            chk("frz_if_ready", if_ready, 1'b0);
            chk("frz_upd", sp_update_valid, 1'b0);
            chk("frz_ib_valid", ib_valid, 1'b1);
            chk("frz_ib_inst", ib_inst, exp_q[0]);
        end
        exp_q.push_back(b.exp);
        rdy = 1;
        tick();
        if_valid = 0; sp_mask_valid = 0;
        chk("frz_upd_after", sp_update_valid, 1'b1);
        chk("frz_upd_pc", sp_updated_pc, b.upd);
        chk("frz_upd_stall", sp_stall, b.stall);
        tick(); tick();

        // Async reset mid-LOOKUP with an occupied FIFO.
        ib_ready = 0;
        run(rnd_item(), 4'd7, 4'd7, 0);
        c = rnd_item();
        if_inst = c.word; if_pc = c.pc; if_valid = 1; if_warp_num = 4'hA;
        tick();
        if_valid = 0;
        chk("rl_lookup", sp_lookup_valid, 1'b1);
        sp_mask_valid = 1;
        rst_n = 0;
        #1;
        exp_q.delete();
        chk("rl_lookup0", sp_lookup_valid, 1'b0);
        chk("rl_ib_valid", ib_valid, 1'b0);
        chk("rl_ib_inst", ib_inst, '0);
        chk("rl_if_ready", if_ready, 1'b0);
        chk("rl_warp", sp_warp_num, 4'h0);
        chk("rl_upd_pc", sp_updated_pc, 32'h0);
        tick();
        rst_n = 1; sp_mask_valid = 0;
        tick();
        chk("rl_no_upd", sp_update_valid, 1'b0);
        chk("rl_empty", ib_valid, 1'b0);
        ib_ready = 1;

        // Random traffic with random I-Buffer backpressure.
        rand_ib = 1;
        for (int i = 0; i < 60; i++)
            run(rnd_item(), 4'($urandom), 4'($urandom), $urandom_range(0, 3));
        rand_ib = 0;
        ib_ready = 1;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        chk("drain", exp_q.size(), 0);
        chk("final_empty", ib_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
